hazard_ctrl: RTL

- Pipeline hazard controller. It produces the stall and flush controls that the pipeline registers consume: PC write-enable, IF/ID write-enable, ID/EX control bubble, and the registered Flush line into IF/ID, ID/EX and EX/MEM.
- Sits beside the ID stage. It watches the instruction in ID/EX for load-use hazards and the branch outcome resolved in MEM.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall and taken-branch flush controller
// with saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rd,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             IF_ID_Uses_rs2,
  input  logic             Branch_Taken,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             Ctrl_Bubble,
  output logic             Flush,
  output logic             Flush_Active,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       flush_d;
  logic       hz;
  logic       stall_inc, flush_inc;

  assign hz = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
              ((ID_EX_rd == IF_ID_rs1) ||
               (IF_ID_Uses_rs2 && (ID_EX_rd == IF_ID_rs2)));

  assign Flush_Active = (state_q == FLUSH);

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    flush_d     = 1'b0;
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    Ctrl_Bubble = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    case (state_q)
      RUN: begin
        // A taken branch squashes the stalled instruction anyway, so it wins.
        if (Branch_Taken) begin
          state_d   = FLUSH;
          fcnt_d    = FLUSH_LOAD;
          flush_d   = 1'b1;
          flush_inc = 1'b1;
        end else if (hz && !reset) begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          Ctrl_Bubble = 1'b1;
          stall_inc   = 1'b1;
        end
      end
      FLUSH: begin
        if (fcnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          fcnt_d  = fcnt_q - 3'd1;
          flush_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      fcnt_q      <= 3'd0;
      Flush       <= 1'b0;
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      Flush   <= flush_d;
      if (stall_inc && (Stall_Count != '1)) Stall_Count <= Stall_Count + CNT_ONE;
      if (flush_inc && (Flush_Count != '1)) Flush_Count <= Flush_Count + CNT_ONE;
    end
  end

endmodule
